// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_if
//  Description : Single-outstanding req/ack data bus between the MEM-stage
//                load/store unit (master) and the data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef RegBus
`define RegBus 31:0
`endif

interface mem_lsu_if;
  logic          dbus_req_o;
  logic          dbus_we_o;
  logic [`RegBus] dbus_addr_o;
  logic [3:0]    dbus_sel_o;
  logic [`RegBus] dbus_wdata_o;
  logic [`RegBus] dbus_rdata_i;
  logic          dbus_ack_i;

  // Load/store unit side
  modport master (
    output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
    input  dbus_rdata_i, dbus_ack_i
  );

  // Memory side
  modport slave (
    input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
    output dbus_rdata_i, dbus_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : MEM-stage load/store unit. Passes non-memory results through
//                with one cycle of latency; runs loads/stores over a
//                single-outstanding req/ack bus with big-endian byte lanes,
//                stalling the pipeline until the ack (or an optional timeout).
//  Options     : MEM_ALIGN_CHK_EN - when defined, misaligned LH/LHU/SH/LW/SW
//                raise a one-cycle excp_align_o pulse instead of a bus access.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif

module mem_lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              valid_i,
  input  wire logic [`AluOpBus]  aluop_i,
  input  wire logic [`RegAddrBus] wd_i,
  input  wire logic              wreg_i,
  input  wire logic [`RegBus]    wdata_i,
  input  wire logic [`RegBus]    mem_addr_i,
  input  wire logic [`RegBus]    reg2_i,
  output logic [`RegAddrBus]     wd_o,
  output logic                   wreg_o,
  output logic [`RegBus]         wdata_o,
  output logic                   stallreq_o,
  mem_lsu_if.master              dbus,
  output logic                   excp_align_o,
  output logic [`RegBus]         badvaddr_o
);

  // Operation encodings shared with the execute stage
  localparam logic [`AluOpBus] c_exe_lb_op  = 8'b1110_0000;
  localparam logic [`AluOpBus] c_exe_lbu_op = 8'b1110_0100;
  localparam logic [`AluOpBus] c_exe_lh_op  = 8'b1110_0001;
  localparam logic [`AluOpBus] c_exe_lhu_op = 8'b1110_0101;
  localparam logic [`AluOpBus] c_exe_lw_op  = 8'b1110_0011;
  localparam logic [`AluOpBus] c_exe_sb_op  = 8'b1110_1000;
  localparam logic [`AluOpBus] c_exe_sh_op  = 8'b1110_1001;
  localparam logic [`AluOpBus] c_exe_sw_op  = 8'b1110_1011;

  // The counter holds the number of ack-less BUSY cycles already elapsed; the
  // abort happens in the cycle where it equals ACK_TIMEOUT-1, i.e. on the edge
  // at which it would reach ACK_TIMEOUT.
  localparam int c_cw = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_cw-1:0] c_tmo_last =
      (ACK_TIMEOUT > 0) ? c_cw'(ACK_TIMEOUT - 1) : '0;
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic [`RegAddrBus] r_wd;
  logic              r_wreg;
  logic [`RegBus]    r_wdata;
  logic              r_req;
  logic              r_we;
  logic [`RegBus]    r_addr;
  logic [3:0]        r_sel;
  logic [`RegBus]    r_bwdata;
  logic [`AluOpBus]  r_op;
  logic [1:0]        r_off;
  logic [c_cw-1:0]   r_cnt;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_is_mem;
  logic              w_start;
  logic [3:0]        w_sel;
  logic [`RegBus]    w_bwdata;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [`RegBus]    w_ld_data;
  logic              w_timeout;

  assign w_is_load  = (aluop_i == c_exe_lb_op)  || (aluop_i == c_exe_lbu_op) ||
                      (aluop_i == c_exe_lh_op)  || (aluop_i == c_exe_lhu_op) ||
                      (aluop_i == c_exe_lw_op);
  assign w_is_store = (aluop_i == c_exe_sb_op)  || (aluop_i == c_exe_sh_op) ||
                      (aluop_i == c_exe_sw_op);
  assign w_is_half  = (aluop_i == c_exe_lh_op)  || (aluop_i == c_exe_lhu_op) ||
                      (aluop_i == c_exe_sh_op);
  assign w_is_word  = (aluop_i == c_exe_lw_op)  || (aluop_i == c_exe_sw_op);
  assign w_is_mem   = valid_i & (w_is_load | w_is_store);

`ifdef MEM_ALIGN_CHK_EN
  logic              w_misalign;
  logic              r_excp;
  logic [`RegBus]    r_badv;

  assign w_misalign = w_is_mem & ((w_is_half & mem_addr_i[0]) |
                                  (w_is_word & (|mem_addr_i[1:0])));
  assign w_start    = w_is_mem & ~w_misalign;
  assign excp_align_o = r_excp;
  assign badvaddr_o   = r_badv;
`else
  assign w_start    = w_is_mem;
  assign excp_align_o = 1'b0;
  assign badvaddr_o   = '0;
`endif

  // Big-endian lane enables, replicated store data and effective lane offset
  always_comb begin
    w_sel    = 4'b0000;
    w_bwdata = '0;
    w_off    = mem_addr_i[1:0];
    if (w_is_word) begin
      w_sel    = 4'b1111;
      w_bwdata = reg2_i;
      w_off    = 2'b00;
    end else if (w_is_half) begin
      w_sel    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      w_bwdata = {2{reg2_i[15:0]}};
      w_off    = {mem_addr_i[1], 1'b0};
    end else begin
      case (mem_addr_i[1:0])
        2'b00:   w_sel = 4'b1000;
        2'b01:   w_sel = 4'b0100;
        2'b10:   w_sel = 4'b0010;
        default: w_sel = 4'b0001;
      endcase
      w_bwdata = {4{reg2_i[7:0]}};
    end
  end

  // Extract and extend the addressed lane(s) of the returned read data
  always_comb begin
    w_byte    = 8'h00;
    w_half    = r_off[1] ? dbus.dbus_rdata_i[15:0] : dbus.dbus_rdata_i[31:16];
    w_ld_data = '0;
    case (r_off)
      2'b00:   w_byte = dbus.dbus_rdata_i[31:24];
      2'b01:   w_byte = dbus.dbus_rdata_i[23:16];
      2'b10:   w_byte = dbus.dbus_rdata_i[15:8];
      default: w_byte = dbus.dbus_rdata_i[7:0];
    endcase
    case (r_op)
      c_exe_lb_op:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      c_exe_lbu_op: w_ld_data = {24'h000000, w_byte};
      c_exe_lh_op:  w_ld_data = {{16{w_half[15]}}, w_half};
      c_exe_lhu_op: w_ld_data = {16'h0000, w_half};
      default:      w_ld_data = dbus.dbus_rdata_i;
    endcase
  end

  assign w_timeout = (ACK_TIMEOUT != 0) && (r_state == ST_BUSY) &&
                     !dbus.dbus_ack_i && (r_cnt == c_tmo_last);

  // Stall while a memory op is being launched or is waiting for its ack
  assign stallreq_o = rst & (((r_state == ST_IDLE) & w_start) |
                             ((r_state == ST_BUSY) & ~dbus.dbus_ack_i & ~w_timeout));

  // Access FSM with registered write-back and bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
      r_wdata  <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_sel    <= 4'b0000;
      r_bwdata <= '0;
      r_op     <= '0;
      r_off    <= 2'b00;
      r_cnt    <= '0;
`ifdef MEM_ALIGN_CHK_EN
      r_excp   <= 1'b0;
      r_badv   <= '0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHK_EN
      r_excp <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
`ifdef MEM_ALIGN_CHK_EN
            if (w_misalign) begin
              r_excp <= 1'b1;
              r_badv <= mem_addr_i;
              r_wreg <= 1'b0;
            end else
`endif
            begin
              r_state  <= ST_BUSY;
              r_req    <= 1'b1;
              r_we     <= w_is_store;
              r_addr   <= {mem_addr_i[31:2], 2'b00};
              r_sel    <= w_sel;
              r_bwdata <= w_bwdata;
              r_op     <= aluop_i;
              r_off    <= w_off;
              r_cnt    <= '0;
              r_wreg   <= 1'b0;
            end
          end else begin
            r_wd    <= wd_i;
            r_wreg  <= wreg_i & valid_i;
            r_wdata <= wdata_i;
          end
        end
        ST_BUSY: begin
          if (dbus.dbus_ack_i) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            if (!r_we) begin
              r_wd    <= wd_i;
              r_wreg  <= wreg_i;
              r_wdata <= w_ld_data;
            end else begin
              r_wreg  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_wreg  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_wreg  <= 1'b0;
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_wreg  <= 1'b0;
        end
      endcase
    end
  end

  assign wd_o    = r_wd;
  assign wreg_o  = r_wreg;
  assign wdata_o = r_wdata;

  assign dbus.dbus_req_o   = r_req;
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = r_addr;
  assign dbus.dbus_sel_o   = r_sel;
  assign dbus.dbus_wdata_o = r_bwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu: hand-computed vector table,
//                directed multi-cycle sequences, and randomized accesses
//                checked against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_mem_lsu;

  localparam int TMO = 4;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_OR  = 8'h25;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
    logic        e_wreg;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        excp_align_o;
  logic [31:0] badvaddr_o;

  int n_chk  = 0;
  int n_fail = 0;

  mem_lsu_if bus ();

  mem_lsu #(.ACK_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .aluop_i      (aluop_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stallreq_o   (stallreq_o),
    .dbus         (bus),
    .excp_align_o (excp_align_o),
    .badvaddr_o   (badvaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic on the rules) ----------
  function automatic int m_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit m_is_load(input logic [7:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW);
  endfunction

  function automatic int m_off(input logic [7:0] op, input logic [31:0] a);
    int sz = m_size(op);
    int o  = int'(a % 32'd4);
    if (sz == 4) return 0;
    if (sz == 2) return (o / 2) * 2;
    return o;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    int sz = m_size(op);
    int o  = m_off(op, a);
    for (int i = 0; i < sz; i++) s[3 - (o + i)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r);
    int sz = m_size(op);
    if (sz == 1) return (r & 32'hFF) * 32'h01010101;
    if (sz == 2) return (r & 32'hFFFF) * 32'h00010001;
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz = m_size(op);
    int o  = m_off(op, a);
    logic [31:0] mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 32'd1);
    logic [31:0] v = (rd >> (8 * (4 - o - sz))) & mask;
    bit sgn = (op == OP_LB || op == OP_LH);
    if (sgn && (((v >> (8 * sz - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t m_vec(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] r2, input logic [31:0] rd,
                                 input int dly, input logic wr);
    vec_t v;
    v.op = op; v.addr = a; v.reg2 = r2; v.rdata = rd; v.delay = dly;
    v.e_addr  = a - (a % 32'd4);
    v.e_sel   = m_sel(op, a);
    v.e_we    = !m_is_load(op);
    v.e_wdata = m_wdata(op, r2);
    v.e_res   = m_is_load(op) ? m_load(op, a, rd) : 32'h0;
    v.e_wreg  = m_is_load(op) ? wr : 1'b0;
    return v;
  endfunction

  // ---------------- stimulus tasks ------------------------------------------
  task automatic run_pass(input logic [7:0] op, input logic [4:0] wd, input logic wr,
                          input logic vld, input logic [31:0] d, input string nm);
    @(posedge clk); #1;
    valid_i = vld; aluop_i = op; wd_i = wd; wreg_i = wr; wdata_i = d;
    mem_addr_i = $urandom; reg2_i = $urandom;
    @(negedge clk);
    chk({nm, " stall"}, 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk({nm, " wd_o"},    32'(wd_o),    32'(wd));
    chk({nm, " wreg_o"},  32'(wreg_o),  32'(wr & vld));
    chk({nm, " wdata_o"}, wdata_o,      d);
    chk({nm, " req"},     32'(bus.dbus_req_o), 32'h0);
  endtask

  task automatic run_mem(input vec_t v, input logic [4:0] wd, input logic wr, input string nm);
    @(posedge clk); #1;
    valid_i = 1'b1; aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
    wd_i = wd; wreg_i = wr; wdata_i = $urandom;
    bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = $urandom;
    @(negedge clk);
    chk({nm, " idle stall"}, 32'(stallreq_o), 32'h1);
    chk({nm, " idle req"},   32'(bus.dbus_req_o), 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < v.delay; k++) begin
      @(negedge clk);
      chk({nm, " wait stall"}, 32'(stallreq_o), 32'h1);
      chk({nm, " wait req"},   32'(bus.dbus_req_o), 32'h1);
      @(posedge clk); #1;
    end
    bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = v.rdata;
    @(negedge clk);
    chk({nm, " ack stall"}, 32'(stallreq_o), 32'h0);
    chk({nm, " ack req"},   32'(bus.dbus_req_o), 32'h1);
    chk({nm, " addr"},      bus.dbus_addr_o, v.e_addr);
    chk({nm, " sel"},       32'(bus.dbus_sel_o), 32'(v.e_sel));
    chk({nm, " we"},        32'(bus.dbus_we_o), 32'(v.e_we));
    chk({nm, " bubble"},    32'(wreg_o), 32'h0);
    if (v.e_we) chk({nm, " bus wdata"}, bus.dbus_wdata_o, v.e_wdata);
    @(posedge clk); #1;
    valid_i = 1'b0; aluop_i = OP_OR; wreg_i = 1'b0;
    bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = $urandom;
    @(negedge clk);
    chk({nm, " done req"},   32'(bus.dbus_req_o), 32'h0);
    chk({nm, " done stall"}, 32'(stallreq_o), 32'h0);
    chk({nm, " wreg_o"},     32'(wreg_o), 32'(v.e_wreg));
    if (!v.e_we) begin
      chk({nm, " wdata_o"}, wdata_o, v.e_res);
      chk({nm, " wd_o"},    32'(wd_o), 32'(wd));
    end
  endtask

  // ---------------- test sequence -------------------------------------------
  vec_t tbl[9];

  initial begin
    tbl[0] = '{OP_LB,  32'h103, 32'h0,        32'h123456F0, 3, 32'h100, 4'b0001, 1'b0, 32'h0,        32'hFFFFFFF0, 1'b1};
    tbl[1] = '{OP_LBU, 32'h103, 32'h0,        32'h123456F0, 3, 32'h100, 4'b0001, 1'b0, 32'h0,        32'h000000F0, 1'b1};
    tbl[2] = '{OP_SH,  32'h202, 32'hABCD1234, 32'h0,        1, 32'h200, 4'b0011, 1'b1, 32'h12341234, 32'h0,        1'b0};
    tbl[3] = '{OP_LH,  32'h200, 32'h0,        32'h80017FFF, 0, 32'h200, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001, 1'b1};
    tbl[4] = '{OP_LHU, 32'h202, 32'h0,        32'h8001F00D, 2, 32'h200, 4'b0011, 1'b0, 32'h0,        32'h0000F00D, 1'b1};
    tbl[5] = '{OP_SW,  32'h3FC, 32'hDEADBEEF, 32'h0,        0, 32'h3FC, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[6] = '{OP_SB,  32'h401, 32'h000000A5, 32'h0,        1, 32'h400, 4'b0100, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[7] = '{OP_LW,  32'h500, 32'h0,        32'hCAFEBABE, 2, 32'h500, 4'b1111, 1'b0, 32'h0,        32'hCAFEBABE, 1'b1};
    tbl[8] = '{OP_LB,  32'h502, 32'h0,        32'h11228033, 0, 32'h500, 4'b0010, 1'b0, 32'h0,        32'hFFFFFF80, 1'b1};

    rst = 1'b0; valid_i = 1'b0; aluop_i = OP_OR; wd_i = 5'd0; wreg_i = 1'b0;
    wdata_i = 32'h0; mem_addr_i = 32'h0; reg2_i = 32'h0;
    bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wd_o",    32'(wd_o), 32'h0);
    chk("reset wreg_o",  32'(wreg_o), 32'h0);
    chk("reset wdata_o", wdata_o, 32'h0);
    chk("reset stall",   32'(stallreq_o), 32'h0);
    chk("reset req",     32'(bus.dbus_req_o), 32'h0);
    chk("reset sel",     32'(bus.dbus_sel_o), 32'h0);
    chk("reset excp",    32'(excp_align_o), 32'h0);
    chk("reset badv",    badvaddr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Pass-through
    run_pass(OP_OR, 5'd5, 1'b1, 1'b1, 32'h0000FFFF, "pass OR");
    run_pass(OP_LW, 5'd9, 1'b1, 1'b0, 32'h12345678, "pass invalid LW");

    // Table vectors
    for (int i = 0; i < 9; i++) run_mem(tbl[i], 5'(i + 1), 1'b1, $sformatf("vec%0d", i));

    // Timeout: LW with no ack
    @(posedge clk); #1;
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h600; wd_i = 5'd9; wreg_i = 1'b1;
    bus.dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("tmo idle stall", 32'(stallreq_o), 32'h1);
    @(posedge clk); #1;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      chk($sformatf("tmo busy%0d req", k),   32'(bus.dbus_req_o), 32'h1);
      chk($sformatf("tmo busy%0d stall", k), 32'(stallreq_o), (k < TMO - 1) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; wreg_i = 1'b0; aluop_i = OP_OR;
    @(negedge clk);
    chk("tmo after req",   32'(bus.dbus_req_o), 32'h0);
    chk("tmo after wreg",  32'(wreg_o), 32'h0);
    chk("tmo after stall", 32'(stallreq_o), 32'h0);
    run_mem(tbl[7], 5'd12, 1'b1, "post-tmo LW");

    // Reset in the middle of an access, stale ack afterwards
    @(posedge clk); #1;
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h700; wd_i = 5'd3; wreg_i = 1'b1;
    @(negedge clk);
    chk("rstmid idle stall", 32'(stallreq_o), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid busy req", 32'(bus.dbus_req_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0; aluop_i = OP_OR; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1; bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("rstmid req",     32'(bus.dbus_req_o), 32'h0);
    chk("rstmid wreg_o",  32'(wreg_o), 32'h0);
    chk("rstmid wdata_o", wdata_o, 32'h0);
    chk("rstmid wd_o",    32'(wd_o), 32'h0);
    chk("rstmid stall",   32'(stallreq_o), 32'h0);
    chk("rstmid addr",    bus.dbus_addr_o, 32'h0);
    @(posedge clk); #1;
    bus.dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("stale ack wreg_o",  32'(wreg_o), 32'h0);
    chk("stale ack wdata_o", wdata_o, 32'h0);
    chk("stale ack req",     32'(bus.dbus_req_o), 32'h0);
    run_mem(tbl[0], 5'd4, 1'b1, "post-rst LB");

    // Misaligned word access
`ifdef MEM_ALIGN_CHK_EN
    @(posedge clk); #1;
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h301; wd_i = 5'd6; wreg_i = 1'b1;
    @(negedge clk);
    chk("align stall", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    valid_i = 1'b0; wreg_i = 1'b0; aluop_i = OP_OR;
    @(negedge clk);
    chk("align excp",   32'(excp_align_o), 32'h1);
    chk("align badv",   badvaddr_o, 32'h301);
    chk("align wreg_o", 32'(wreg_o), 32'h0);
    chk("align req",    32'(bus.dbus_req_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("align excp pulse", 32'(excp_align_o), 32'h0);
    chk("align req after",  32'(bus.dbus_req_o), 32'h0);
`else
    run_mem('{OP_LW, 32'h301, 32'h0, 32'h89ABCDEF, 1, 32'h300, 4'b1111, 1'b0, 32'h0, 32'h89ABCDEF, 1'b1},
            5'd6, 1'b1, "misaligned LW");
    chk("noalign excp", 32'(excp_align_o), 32'h0);
    run_mem('{OP_LH, 32'h203, 32'h0, 32'h1234ABCD, 0, 32'h200, 4'b0011, 1'b0, 32'h0, 32'hFFFFABCD, 1'b1},
            5'd7, 1'b1, "misaligned LH");
`endif

    // Randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] op = 8'($urandom);
        if (m_is_load(op) || op == OP_SB || op == OP_SH || op == OP_SW) op = OP_OR;
        run_pass(op, 5'($urandom), 1'($urandom), 1'($urandom), $urandom,
                 $sformatf("rnd%0d pass", i));
      end else begin
        logic [7:0] ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
        logic [7:0] op = ops[$urandom_range(0, 7)];
        logic [31:0] a = $urandom & ~32'(m_size(op) - 1);
        logic wr = 1'($urandom);
        vec_t v = m_vec(op, a, $urandom, $urandom, int'($urandom_range(0, TMO - 1)), wr);
        run_mem(v, 5'($urandom), wr, $sformatf("rnd%0d op%02h", i, op));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit, directly downstream of the execute stage.
- Consumes the execute stage's destination/write-enable/result, aluop, effective address and store data.
- Runs memory ops over a single-outstanding req/ack data bus, stalling the pipeline while waiting.
- Produces the registered write-back triple (wd_o, wreg_o, wdata_o) for the MEM/WB path.

Parameters:
- ACK_TIMEOUT, 255: max cycles waiting for dbus_ack_i before the access is abandoned. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- valid_i  in  1  input instruction valid
- aluop_i  in  `AluOpBus  operation code from execute
- wd_i  in  `RegAddrBus  destination register
- wreg_i  in  1  destination write enable
- wdata_i  in  `RegBus  execute result (non-memory ops)
- mem_addr_i  in  `RegBus  effective address
- reg2_i  in  `RegBus  store data
- wd_o  out  `RegAddrBus  write-back register
- wreg_o  out  1  write-back enable
- wdata_o  out  `RegBus  write-back data
- stallreq_o  out  1  pipeline stall request (combinational)
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  `RegBus  word address, bits[1:0] = 00
- dbus_sel_o  out  4  byte-lane enables, bit3 = bits[31:24]
- dbus_wdata_o  out  `RegBus  write data
- dbus_rdata_i  in  `RegBus  read data, valid with ack
- dbus_ack_i  in  1  access complete
- excp_align_o  out  1  misalignment pulse (see optional feature)
- badvaddr_o  out  `RegBus  faulting address

Behaviour:
- Reset (rst == 0 at posedge):
  - state IDLE; all outputs 0; timeout counter 0.
  - Applies mid-access: request dropped, pending result discarded, a later stale ack ignored.
- Memory ops: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP. Anything else is pass-through.
- Pass-through (IDLE, not a valid memory op): next edge wd_o←wd_i, wreg_o←wreg_i&valid_i, wdata_o←wdata_i. Latency 1, no stall.
- Byte lanes are big-endian:
  - Address offset 00→lane3, 01→lane2, 10→lane1, 11→lane0.
  - Halfword: addr[1]=0→sel 1100, addr[1]=1→sel 0011. Word: sel 1111.
- Store data: SB={4{reg2_i[7:0]}}, SH={2{reg2_i[15:0]}}, SW=reg2_i.
- Load data: selected lane(s) are sign-extended for LB/LH and zero-extended for LBU/LHU.
- FSM:
  - IDLE, valid memory op:
    - stallreq_o=1 this cycle.
    - Next edge: latch addr/sel/we/wdata, dbus_req_o←1, state→BUSY, wreg_o←0 (bubble).
  - BUSY:
    - dbus_req_o and all bus outputs held stable.
    - stallreq_o = ~dbus_ack_i.
    - On ack edge: req←0, state→IDLE. Load: wreg_o←wreg_i, wd_o←wd_i, wdata_o←extended data. Store: wreg_o←0.
    - Not on ack: wreg_o←0, counter increments.
  - Timeout (ACK_TIMEOUT≠0): counter reaching ACK_TIMEOUT without ack → req←0, wreg_o←0, IDLE. Stall releases in the same cycle.
  - dbus_ack_i in IDLE is ignored.
- Back-to-back memory ops: IDLE and BUSY alternate, so each access costs ≥2 cycles.
- Inputs are assumed held by the upstream stall while stallreq_o=1.

Optional Feature:
- Macro MEM_ALIGN_CHK_EN.
- Defined:
  - Misalignment is LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠00.
  - On a misaligned op in IDLE: no bus access, no stall.
  - Next edge: excp_align_o←1 for one cycle, badvaddr_o←mem_addr_i, wreg_o←0.
- Undefined:
  - excp_align_o and badvaddr_o are tied to 0.
  - Misaligned low address bits are ignored: halfword uses addr[1] only, word forces offset 00.

Test Plan:
- Pass-through: OR result 0x0000FFFF to wd=5, wreg=1 → next cycle wd_o=5, wreg_o=1, wdata_o=0x0000FFFF, stallreq_o never 1.
- LB, addr 0x103, rdata 0x123456F0, ack 3 cycles after req:
  - dbus_addr_o=0x100, sel=0001.
  - stallreq_o high until the ack cycle.
  - wdata_o=0xFFFFFFF0. LBU with the same inputs gives 0x000000F0.
- SH, addr 0x202, reg2=0xABCD1234 → dbus_we_o=1, sel=0011, wdata=0x12341234, wreg_o=0 after ack.
- Timeout: ACK_TIMEOUT=4, LW with ack never asserted → req drops after 4 BUSY cycles, stall releases, no write-back.
- Reset mid-access: rst=0 while BUSY, then ack arrives after reset → all outputs 0, ack ignored, next op served normally.
- MEM_ALIGN_CHK_EN: LW addr 0x301 → no dbus_req_o, excp_align_o pulses once, badvaddr_o=0x301, wreg_o=0.
